// File: rtl/alu_seq_if.sv
// Request/result bundle between a control FSM and the alu_seq datapath.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_hi;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, f, f_hi, carry, zero, ovf, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, f, f_hi, carry, zero, ovf, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flags and a one-cycle done pulse.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier for op 111.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             done_q, busy_q;
  logic [WIDTH-1:0] f_q, f_hi_q;
  logic             carry_q, zero_q, ovf_q, err_q;

  logic [WIDTH:0]   sum, diff;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_c, res_v, res_z, res_e;

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = {1'b0, a_q} - {1'b0, b_q};
  assign shamt = b_q[SW-1:0];

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc;
  logic [SW-1:0]      cnt;
  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] acc_next;

  // Multiplier occupies the low half of acc and is consumed from bit 0 as the
  // partial product shifts in from the top, carry bit included.
  assign acc_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign acc_next = acc[0] ? {acc_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
`endif

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_e  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_lo = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo = diff[WIDTH-1:0];
        res_c  = diff[WIDTH];
        res_v  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_lo = a_q & b_q;
      OP_OR:  res_lo = a_q | b_q;
      OP_XOR: res_lo = a_q ^ b_q;
      OP_SHL: res_lo = a_q << shamt;
      OP_SHR: res_lo = a_q >> shamt;
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        res_lo = acc[WIDTH-1:0];
        res_hi = acc[2*WIDTH-1:WIDTH];
`else
        res_e  = 1'b1;
`endif
      end
      default: res_e = 1'b1;
    endcase
    res_z = ({res_hi, res_lo} == '0);
  end

  // Results register on leaving DONE so f and flags change in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      f_q     <= '0;
      f_hi_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc     <= '0;
      cnt     <= '0;
`endif
    end else begin
      done_q <= (state == S_DONE);
`ifdef ALU_SEQ_MUL_EN
      busy_q <= (state == S_MUL);
`else
      busy_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            state <= S_DONE;
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == OP_MUL) begin
              acc   <= {{WIDTH{1'b0}}, bus.b};
              cnt   <= '0;
              state <= S_MUL;
            end
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(WIDTH - 1)) state <= S_DONE;
        end
`endif
        S_DONE: begin
          f_q     <= res_lo;
          f_hi_q  <= res_hi;
          carry_q <= res_c;
          zero_q  <= res_z;
          ovf_q   <= res_v;
          err_q   <= res_e;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.f     = f_q;
  assign bus.f_hi  = f_hi_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_q;
endmodule
